// File: rtl/pcm_serial_tx_if.sv
// ---------------------------------------------------------------------------
// pcm_serial_tx_if
//   Bundles the sample-input, control, status and three-wire serial signals
//   of pcm_serial_tx.
//
//   Signals (direction seen from the serializer, modport slave):
//     pcm_in    in   DATA_WIDTH        signed PCM sample from the decimator
//     pcm_valid in   1                 one-cycle strobe qualifying pcm_in
//     en        in   1                 serializer enable
//     ovf_clr   in   1                 clears the overflow flag
//     unf_clr   in   1                 clears the underrun flag
//     sclk      out  1                 serial bit clock
//     ws        out  1                 word select (0 = slot A, 1 = slot B)
//     sd        out  1                 serial data, MSB first
//     fill      out  clog2(DEPTH)+1    FIFO occupancy
//     overflow  out  1                 sticky: a sample was dropped
//     underrun  out  1                 sticky: a frame started with FIFO empty
//
//   modport master : the producer/controller side (drives the inputs)
//   modport slave  : the serializer side
// ---------------------------------------------------------------------------
interface pcm_serial_tx_if #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
);
    logic signed [DATA_WIDTH-1:0]     pcm_in;
    logic                             pcm_valid;
    logic                             en;
    logic                             ovf_clr;
    logic                             unf_clr;
    logic                             sclk;
    logic                             ws;
    logic                             sd;
    logic [$clog2(FIFO_DEPTH):0]      fill;
    logic                             overflow;
    logic                             underrun;

    modport master (
        output pcm_in, pcm_valid, en, ovf_clr, unf_clr,
        input  sclk, ws, sd, fill, overflow, underrun
    );

    modport slave (
        input  pcm_in, pcm_valid, en, ovf_clr, unf_clr,
        output sclk, ws, sd, fill, overflow, underrun
    );
endinterface

// File: rtl/pcm_serial_tx.sv
// ---------------------------------------------------------------------------
// pcm_serial_tx
//   Output stage of the decimation chain. Decimated signed PCM words are
//   buffered in a small FIFO and serialized MSB-first onto a left-justified
//   I2S-style interface (sclk/ws/sd). The stream is mono: every sample is
//   transmitted in both the ws=0 and ws=1 slot of one frame.
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   asynchronous active-high reset
//     bus  pcm_serial_tx_if.slave : pcm_in/pcm_valid/en/ovf_clr/unf_clr in,
//          sclk/ws/sd/fill/overflow/underrun out
//
//   Parameters:
//     DATA_WIDTH  sample width
//     FIFO_DEPTH  FIFO entries (power of two, >= 2)
//     SCLK_DIV    clk cycles per sclk half period (>= 1)
//     FRAME_BITS  sclk bits per slot (>= DATA_WIDTH), tail is zero padded
// ---------------------------------------------------------------------------
module pcm_serial_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int SCLK_DIV   = 4,
    parameter int FRAME_BITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    pcm_serial_tx_if.slave   bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FW    = AW + 1;
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int CW    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [CW-1:0]    BIT_LAST = CW'(FRAME_BITS - 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,    state_d;
    logic [AW-1:0]          wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q,   rd_ptr_d;
    logic [FW-1:0]          fill_q,     fill_d;
    logic                   overflow_q, overflow_d;
    logic                   underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0]  sample_q,   sample_d;
    logic [DIV_W-1:0]       div_q,      div_d;
    logic [CW-1:0]          bit_cnt_q,  bit_cnt_d;
    logic                   slot_q,     slot_d;
    logic                   sclk_q,     sclk_d;
    logic                   ws_q,       ws_d;
    logic                   sd_q,       sd_d;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // FIFO status and handshake terms
    // ------------------------------------------------------------------
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [DATA_WIDTH-1:0]  head;
    logic                   pop;        // FSM wants a new sample this cycle
    logic                   pop_ok;     // ... and the FIFO can supply one
    logic                   wr_ok;
    logic                   ovf_set;
    logic                   unf_set;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FILL_MAX);

    // An empty pop delivers silence rather than stale memory contents.
    assign head = fifo_empty ? '0 : mem[rd_ptr_q];

    assign pop_ok  = pop & ~fifo_empty;
    assign unf_set = pop &  fifo_empty;
    // A full FIFO still accepts a write when an entry leaves in the same
    // cycle; only a write with no room and no concurrent pop is dropped.
    assign wr_ok   = bus.pcm_valid & (~fifo_full | pop_ok);
    assign ovf_set = bus.pcm_valid &   fifo_full & ~pop_ok;

    // ------------------------------------------------------------------
    // FIFO bookkeeping and sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        underrun_d = underrun_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_ok, pop_ok})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase

        // Set has priority over clear so an event coincident with a clear
        // is never lost.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end

        if (unf_set) begin
            underrun_d = 1'b1;
        end else if (bus.unf_clr) begin
            underrun_d = 1'b0;
        end
    end

    // Sample storage carries no reset; only pointers and count do.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= bus.pcm_in;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        slot_d    = slot_q;
        sclk_d    = sclk_q;
        ws_d      = ws_q;
        sd_d      = sd_q;
        pop       = 1'b0;
        shifted   = '0;

        case (state_q)
            ST_IDLE: begin
                sclk_d    = 1'b0;
                ws_d      = 1'b0;
                sd_d      = 1'b0;
                div_d     = '0;
                bit_cnt_d = '0;
                slot_d    = 1'b0;
                if (bus.en) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                pop       = 1'b1;
                sample_d  = head;
                sd_d      = head[DATA_WIDTH-1];
                ws_d      = 1'b0;
                sclk_d    = 1'b0;
                div_d     = '0;
                bit_cnt_d = '0;
                slot_d    = 1'b0;
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Data and word select only change on the falling edge
                    // so the receiver sees them stable at the rising edge.
                    if (sclk_q) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            if (!slot_q) begin
                                // Slot B repeats the same sample (mono).
                                slot_d = 1'b1;
                                ws_d   = 1'b1;
                                sd_d   = sample_q[DATA_WIDTH-1];
                            end else if (bus.en) begin
                                // Back-to-back frame: fetch the next sample
                                // on this very edge so there is no gap.
                                pop      = 1'b1;
                                sample_d = head;
                                slot_d   = 1'b0;
                                ws_d     = 1'b0;
                                sd_d     = head[DATA_WIDTH-1];
                            end else begin
                                state_d = ST_IDLE;
                                slot_d  = 1'b0;
                                ws_d    = 1'b0;
                                sd_d    = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                            // Shifting past the sample width leaves zeros,
                            // which gives the tail padding for free.
                            shifted   = sample_q << bit_cnt_d;
                            sd_d      = shifted[DATA_WIDTH-1];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            sample_q   <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            slot_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            sample_q   <= sample_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_q     <= slot_d;
            sclk_q     <= sclk_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.ws       = ws_q;
    assign bus.sd       = sd_q;
    assign bus.fill     = fill_q;
    assign bus.overflow = overflow_q;
    assign bus.underrun = underrun_q;

endmodule

// File: doc/pcm_serial_tx.md
Name: pcm_serial_tx

Overview:
- Output stage directly downstream of the decimation chain (CIC → compensation FIR → half-band).
- Accepts decimated signed PCM words with a valid strobe and buffers them in a small synchronous FIFO.
- Serializes each sample MSB-first onto a left-justified, I2S-style three-wire interface (sclk/ws/sd) for an external codec or capture device.
- Mono stream: each sample is sent in both the ws=0 and ws=1 slots of one frame.

Parameters:
- DATA_WIDTH, 24: PCM sample width. Matches the decimator OUT_WIDTH.
- FIFO_DEPTH, 8: FIFO entries. Power of 2, ≥2.
- SCLK_DIV, 4: clk cycles per sclk half-period. ≥1.
- FRAME_BITS, 32: sclk bits per slot. ≥DATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcm_in  in  DATA_WIDTH  signed sample from the decimator.
- pcm_valid  in  1  one-cycle strobe qualifying pcm_in. No backpressure.
- en  in  1  serializer enable.
- ovf_clr  in  1  clears the overflow flag.
- unf_clr  in  1  clears the underrun flag.
- sclk  out  1  serial bit clock.
- ws  out  1  word select: 0 = slot A, 1 = slot B.
- sd  out  1  serial data, MSB first.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a sample was dropped.
- underrun  out  1  sticky flag: a frame started with the FIFO empty.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - sclk=0, ws=0, sd=0, fill=0, overflow=0, underrun=0.
  - FIFO pointers cleared, FSM in IDLE, divider and bit counters cleared.
- FIFO write:
  - pcm_valid=1 and not full → write; fill increments the next cycle.
  - pcm_valid=1 and full, with no pop that cycle → sample dropped, overflow←1.
  - Write and pop in the same cycle when full → both happen, fill unchanged, no overflow.
  - Write and pop in the same cycle when empty → pop yields nothing (underrun path); write lands; fill=1.
- Flags:
  - overflow/underrun stay set until the matching *_clr.
  - Set and clear in the same cycle → set wins.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: sclk=0, ws=0, sd=0, divider held at 0. Leave for LOAD when en=1.
  - LOAD (1 cycle):
    - FIFO not empty → pop head into shift register.
    - FIFO empty → load 0 and set underrun.
    - Then go to SHIFT with ws=0, sd=MSB, bit_cnt=0, slot=0, divider=0, sclk=0.
  - SHIFT:
    - Divider counts 0..SCLK_DIV-1; at terminal count sclk toggles. sclk period = 2*SCLK_DIV clk cycles.
    - All sd/ws updates happen only on the sclk 1→0 transition (the "fall event"). The receiver samples on sclk rising.
    - Fall event: bit_cnt++. sd = sample bit (DATA_WIDTH-1-bit_cnt) while bit_cnt<DATA_WIDTH, else 0.
    - Fall event at bit_cnt=FRAME_BITS-1 with slot=0 → slot=1, ws=1, bit_cnt=0, sd=MSB of the same sample.
    - Fall event ending slot 1 (end of frame):
      - en=1 → pop the next sample (or zero + underrun) in that same cycle; ws=0, sd=MSB, bit_cnt=0; stay in SHIFT with no gap.
      - en=0 → go to IDLE (current frame always completes).
- en deasserted mid-frame has no effect until the frame ends.
- fill counts only stored entries. The sample in the shift register is excluded.
- Latency: sample written into an empty FIFO while IDLE, with en=1 → ws=0 and sd=MSB appear 2 cycles after the write cycle.
- Width rules:
  - sd carries the raw two's-complement bits; no rounding or truncation.
  - FRAME_BITS>DATA_WIDTH → zero padding at the slot tail.

Test Plan:
- Reset: assert rst mid-SHIFT → all outputs 0 asynchronously; after release, FSM is IDLE with fill=0.
- Single sample (DATA_WIDTH=24, FRAME_BITS=32, SCLK_DIV=2): write 0xA5F00F, en=1 → sclk period 4 clk.
  - ws=0 for 32 sclk: sd = 1010_0101_1111_0000_0000_1111 then 8 zeros.
  - ws=1 for 32 sclk: identical bits.
  - Next frame all zeros with underrun=1.
- Overflow (FIFO_DEPTH=4), en=0: write 0x000001..0x000005 → fill=4, overflow=1.
  - en=1 → frames carry 1, 2, 3, 4, then underrun.
  - ovf_clr → overflow=0.
- Underrun recovery: en=1 with empty FIFO → first frame zero, underrun=1.
  - Write 0x7FFFFF mid-frame → transmitted in the next frame; fill returns to 0 at that frame start.
- Full plus simultaneous pop: FIFO full, pcm_valid coincident with the frame-boundary pop → write accepted, fill stays 4, overflow stays 0.
- Graceful stop: drop en at bit 5 of slot 0 → frame completes (64 sclk), then sclk/ws/sd held 0 and no extra pop.
